// File: rtl/display_pkg.sv
// Shared types and constants for the display scanner.
package display_pkg;

  // Scan sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CAPTURE,
    EMIT,
    DONE
  } state_e;

  // Line layout: five name characters, a colon, eight hex digits.
  localparam int CHARS_PER_LINE = 14;
  localparam int NAME_CHARS     = 5;
  localparam int HEX_CHARS      = 8;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Character positions within a line.
  localparam logic [3:0] COLON_POS = 4'(NAME_CHARS);
  localparam logic [3:0] LAST_POS  = 4'(CHARS_PER_LINE - 1);

endpackage

// File: rtl/hex_to_ascii.sv
// Maps one 4-bit nibble to its ASCII hex digit.
module hex_to_ascii #(
  parameter bit HEX_UPPER = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 0-9 -> '0'-'9'; 10-15 -> 'A'-'F' or 'a'-'f' (offset folds in the -10).
  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'h0, nibble};
    end else if (HEX_UPPER) begin
      ascii = 8'h37 + {4'h0, nibble};
    end else begin
      ascii = 8'h57 + {4'h0, nibble};
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Walks display entries 1..NUM_ENTRIES, fetches each one from the responder
// and streams every valid entry as a 14-character text line to the sink.
module display_scanner
  import display_pkg::*;
#(
  parameter logic [5:0] NUM_ENTRIES = 6'd4,
  parameter bit         HEX_UPPER   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_start,
  output logic [5:0]  display_number,
  input  logic        display_valid,
  input  logic [39:0] display_name,
  input  logic [31:0] display_value,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [7:0]  char_data,
  output logic        char_last,
  output logic [5:0]  line_index,
  output logic        scan_busy,
  output logic        scan_done
);

  state_e      state_q, state_d;
  logic [5:0]  index_q, index_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        shadow_valid_q, shadow_valid_d;
  logic [39:0] shadow_name_q, shadow_name_d;
  logic [31:0] shadow_value_q, shadow_value_d;

  logic [5:0]  display_number_q, display_number_d;
  logic        char_valid_q, char_valid_d;
  logic [7:0]  char_data_q, char_data_d;
  logic        char_last_q, char_last_d;
  logic [5:0]  line_index_q, line_index_d;
  logic        scan_busy_q, scan_busy_d;
  logic        scan_done_q, scan_done_d;

  logic        advance;
  logic [7:0]  name_byte;
  logic [3:0]  hex_nibble;
  logic [7:0]  hex_char;
  logic [7:0]  char_sel;

  // Sequencer: state, entry index, character count and shadow capture.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    state_d        = state_q;
    index_d        = index_q;
    cnt_d          = cnt_q;
    shadow_valid_d = shadow_valid_q;
    shadow_name_d  = shadow_name_q;
    shadow_value_d = shadow_value_q;
    advance        = 1'b0;

    case (state_q)
      IDLE: begin
        if (scan_start) begin
          state_d = REQ;
          index_d = 6'd1;
        end
      end
      REQ:  state_d = WAIT;
      WAIT: state_d = CAPTURE;
      CAPTURE: begin
        shadow_valid_d = display_valid;
        shadow_name_d  = display_name;
        shadow_value_d = display_value;
        if (display_valid) begin
          state_d = EMIT;
          cnt_d   = 4'd0;
        end else begin
          advance = 1'b1;
        end
      end
      EMIT: begin
        if (char_valid_q && char_ready) begin
          if (cnt_q == LAST_POS) begin
            advance = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Move to the next entry, or finish once the last index has been handled.
    if (advance) begin
      if (index_q == NUM_ENTRIES) begin
        state_d = DONE;
      end else begin
        index_d = index_q + 6'd1;
        state_d = REQ;
      end
    end
  end

  // Pick the name byte and value nibble addressed by the upcoming char count.
  always_comb begin
    name_byte  = 8'h00;
    hex_nibble = 4'h0;
    for (int k = 0; k < NAME_CHARS; k++) begin
      if (cnt_d == 4'(k)) name_byte = shadow_name_d[8*(NAME_CHARS-1-k) +: 8];
    end
    for (int k = 0; k < HEX_CHARS; k++) begin
      if (cnt_d == 4'(NAME_CHARS + 1 + k)) hex_nibble = shadow_value_d[4*(HEX_CHARS-1-k) +: 4];
    end
  end

  hex_to_ascii #(
    .HEX_UPPER(HEX_UPPER)
  ) u_hex_to_ascii (
    .nibble(hex_nibble),
    .ascii (hex_char)
  );

  // Assemble the character for the upcoming line position.
  always_comb begin
    if (cnt_d < COLON_POS) begin
      char_sel = (name_byte == 8'h00) ? ASCII_SPACE : name_byte;
    end else if (cnt_d == COLON_POS) begin
      char_sel = ASCII_COLON;
    end else begin
      char_sel = hex_char;
    end
  end

  // Output values derived from the next state so every output is registered.
  always_comb begin
    display_number_d = display_number_q;
    if (state_d == IDLE) begin
      display_number_d = 6'd0;
    end else if (state_d == REQ) begin
      display_number_d = index_d;
    end

    char_valid_d = (state_d == EMIT) && shadow_valid_d;
    char_data_d  = char_valid_d ? char_sel : char_data_q;
    char_last_d  = char_valid_d && (cnt_d == LAST_POS);
    line_index_d = char_valid_d ? index_d : line_index_q;
    scan_busy_d  = (state_d != IDLE);
    scan_done_d  = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (reset) begin
      state_q          <= IDLE;
      index_q          <= 6'd0;
      cnt_q            <= 4'd0;
      // NOTE: the shadow registers are reset too, so an abandoned line never
      // leaves stale entry data visible after reset.
      shadow_valid_q   <= 1'b0;
      shadow_name_q    <= 40'd0;
      shadow_value_q   <= 32'd0;
      display_number_q <= 6'd0;
      char_valid_q     <= 1'b0;
      char_data_q      <= 8'd0;
      char_last_q      <= 1'b0;
      line_index_q     <= 6'd0;
      scan_busy_q      <= 1'b0;
      scan_done_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      index_q          <= index_d;
      cnt_q            <= cnt_d;
      shadow_valid_q   <= shadow_valid_d;
      shadow_name_q    <= shadow_name_d;
      shadow_value_q   <= shadow_value_d;
      display_number_q <= display_number_d;
      char_valid_q     <= char_valid_d;
      char_data_q      <= char_data_d;
      char_last_q      <= char_last_d;
      line_index_q     <= line_index_d;
      scan_busy_q      <= scan_busy_d;
      scan_done_q      <= scan_done_d;
    end
  end

  assign display_number = display_number_q;
  assign char_valid     = char_valid_q;
  assign char_data      = char_data_q;
  assign char_last      = char_last_q;
  assign line_index     = line_index_q;
  assign scan_busy      = scan_busy_q;
  assign scan_done      = scan_done_q;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: a table-driven responder, a sink
// monitor, and a text-level reference model of the expected character stream.
module tb_display_scanner;

  typedef logic [14:0] ent_t;  // {line_index, char_last, char_data}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        scan_start = 1'b0, scan_start_lc = 1'b0;
  logic        char_ready = 1'b1, char_ready_lc = 1'b1;
  logic [5:0]  display_number, display_number_lc;
  logic        display_valid, display_valid_lc;
  logic [39:0] display_name, display_name_lc;
  logic [31:0] display_value, display_value_lc;
  logic        char_valid, char_valid_lc;
  logic [7:0]  char_data, char_data_lc;
  logic        char_last, char_last_lc;
  logic [5:0]  line_index, line_index_lc;
  logic        scan_busy, scan_busy_lc;
  logic        scan_done, scan_done_lc;

  display_scanner #(.NUM_ENTRIES(6'd4), .HEX_UPPER(1'b1)) dut (
    .clk(clk), .reset(reset), .scan_start(scan_start),
    .display_number(display_number), .display_valid(display_valid),
    .display_name(display_name), .display_value(display_value),
    .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
    .char_last(char_last), .line_index(line_index),
    .scan_busy(scan_busy), .scan_done(scan_done)
  );

  display_scanner #(.NUM_ENTRIES(6'd1), .HEX_UPPER(1'b0)) dut_lc (
    .clk(clk), .reset(reset), .scan_start(scan_start_lc),
    .display_number(display_number_lc), .display_valid(display_valid_lc),
    .display_name(display_name_lc), .display_value(display_value_lc),
    .char_valid(char_valid_lc), .char_ready(char_ready_lc), .char_data(char_data_lc),
    .char_last(char_last_lc), .line_index(line_index_lc),
    .scan_busy(scan_busy_lc), .scan_done(scan_done_lc)
  );

  // Display table and one-cycle-latency responders.
  logic        tbl_valid [64];
  logic [39:0] tbl_name  [64];
  logic [31:0] tbl_val   [64];

  always @(posedge clk) begin
    display_valid    <= tbl_valid[display_number];
    display_name     <= tbl_name[display_number];
    display_value    <= tbl_val[display_number];
    display_valid_lc <= tbl_valid[display_number_lc];
    display_name_lc  <= tbl_name[display_number_lc];
    display_value_lc <= tbl_val[display_number_lc];
  end

  // Sink ready pattern: always ready, or ready on roughly one cycle in three.
  int ready_mode = 0;
  initial forever begin
    @(negedge clk);
    char_ready = (ready_mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b1;
  end

  // Sink monitor: accepted characters, stall stability, done pulses.
  ent_t       got_q[$], got_lc_q[$], exp_q[$];
  int         stall_errs = 0, valid_cycles = 0, done_pulses = 0, done_cycles = 0;
  logic [5:0] dn_max = 6'd0;
  logic       stall_pend = 1'b0, done_prev = 1'b0;
  ent_t       stall_ent = '0;

  always @(posedge clk) begin
    if (char_valid && char_ready) got_q.push_back({line_index, char_last, char_data});
    if (char_valid_lc && char_ready_lc) got_lc_q.push_back({line_index_lc, char_last_lc, char_data_lc});
    if (char_valid) valid_cycles++;
    if (stall_pend && !reset && ({char_valid, line_index, char_last, char_data} !== {1'b1, stall_ent}))
      stall_errs++;
    stall_pend = char_valid && !char_ready;
    stall_ent  = {line_index, char_last, char_data};
    if (scan_done) done_cycles++;
    if (scan_done && !done_prev) done_pulses++;
    done_prev = scan_done;
    if (display_number > dn_max) dn_max = display_number;
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: render one table entry as its text line.
  function automatic void add_line(input int idx, input bit upper);
    logic [39:0] nm = tbl_name[idx];
    string       hx = $sformatf("%08h", tbl_val[idx]);
    logic [7:0]  c;
    for (int k = 0; k < 5; k++) begin
      c = nm[39-8*k -: 8];
      if (c == 8'h00) c = " ";
      exp_q.push_back({6'(idx), 1'b0, c});
    end
    exp_q.push_back({6'(idx), 1'b0, 8'h3A});
    for (int k = 0; k < 8; k++) begin
      c = hx[k];
      if (upper && c >= "a") c = c - 8'd32;
      exp_q.push_back({6'(idx), (k == 7), c});
    end
  endfunction

  function automatic logic [39:0] rand_name();
    logic [39:0] n;
    for (int k = 0; k < 5; k++)
      n[8*k +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(33, 126));
    return n;
  endfunction

  task automatic cmp_stream(input string tag, input ent_t got[$], input ent_t exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s_ch%0d", tag, i), got[i], exp[i]);
  endtask

  task automatic cmp_literal(input string tag, input ent_t got[$], input string s);
    if (got.size() < s.len()) check({tag, "_short"}, got.size(), s.len());
    else for (int i = 0; i < s.len(); i++) check($sformatf("%s_lit%0d", tag, i), got[i][7:0], s[i]);
  endtask

  task automatic clear_mon();
    got_q.delete(); got_lc_q.delete(); exp_q.delete();
    stall_errs = 0; valid_cycles = 0; done_pulses = 0; done_cycles = 0; dn_max = 6'd0;
  endtask

  task automatic pulse_start();
    @(negedge clk) scan_start = 1'b1;
    @(negedge clk) scan_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit lc);
    int n = 0;
    while (((lc ? scan_done_lc : scan_done) !== 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, lc ? scan_done_lc : scan_done, 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) begin
      tbl_valid[i] = 1'b0; tbl_name[i] = '0; tbl_val[i] = '0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_dn", display_number, 0);
    check("rst_cvalid", char_valid, 0);
    check("rst_clast", char_last, 0);
    check("rst_cdata", char_data, 0);
    check("rst_line", line_index, 0);
    check("rst_busy", scan_busy, 0);
    check("rst_done", scan_done, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Scan A: entries 1 and 4 valid, 2 and 3 invalid, zero-wait sink.
    tbl_valid[1] = 1'b1; tbl_name[1] = "SRC_1"; tbl_val[1] = 32'h12345678;
    tbl_valid[4] = 1'b1; tbl_name[4] = rand_name(); tbl_name[4][23:16] = 8'h00;
    tbl_val[4] = $urandom;
    clear_mon();
    add_line(1, 1'b1); add_line(4, 1'b1);
    pulse_start();
    check("a_busy", scan_busy, 1);
    check("a_dn_first", display_number, 1);
    n = 0;
    while (char_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("a_emit_seen", char_valid, 1);
    check("a_line1", line_index, 1);
    // Responder changes and a stray scan_start during EMIT must have no effect.
    tbl_name[1] = ~tbl_name[1]; tbl_val[1] = ~tbl_val[1];
    pulse_start();
    wait_done("a", 1'b0);
    scan_start = 1'b1;  // request in the DONE cycle is ignored
    @(negedge clk) scan_start = 1'b0;
    check("a_busy_after", scan_busy, 0);
    check("a_done_after", scan_done, 0);
    repeat (3) @(negedge clk);
    check("a_idle_busy", scan_busy, 0);
    check("a_idle_dn", display_number, 0);
    cmp_stream("a", got_q, exp_q);
    cmp_literal("a1", got_q, "SRC_1:12345678");
    check("a_valid_cycles", valid_cycles, 28);
    check("a_dn_max", dn_max, 4);
    check("a_done_pulses", done_pulses, 1);
    check("a_done_width", done_cycles, 1);

    // Scan B: random tables, sink ready about one cycle in three.
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= 4; i++) begin
        tbl_valid[i] = 1'($urandom_range(0, 1));
        tbl_name[i]  = rand_name();
        tbl_val[i]   = $urandom;
      end
      clear_mon();
      for (int i = 1; i <= 4; i++) if (tbl_valid[i]) add_line(i, 1'b1);
      ready_mode = 1;
      pulse_start();
      check($sformatf("b%0d_restart_dn", r), display_number, 1);
      wait_done($sformatf("b%0d", r), 1'b0);
      ready_mode = 0;
      repeat (3) @(negedge clk);
      cmp_stream($sformatf("b%0d", r), got_q, exp_q);
      check($sformatf("b%0d_stall", r), stall_errs, 0);
      check($sformatf("b%0d_done_pulses", r), done_pulses, 1);
      check($sformatf("b%0d_dn_max", r), dn_max, 4);
    end

    // Scan C: lowercase hex, NUL name bytes, single-entry scan.
    tbl_valid[1] = 1'b1; tbl_name[1] = 40'h0; tbl_val[1] = 32'h00ABCDEF;
    clear_mon();
    add_line(1, 1'b0);
    @(negedge clk) scan_start_lc = 1'b1;
    @(negedge clk) scan_start_lc = 1'b0;
    wait_done("c", 1'b1);
    repeat (2) @(negedge clk);
    cmp_stream("c", got_lc_q, exp_q);
    cmp_literal("c", got_lc_q, "     :00abcdef");
    check("c_busy_after", scan_busy_lc, 0);

    // Scan D: reset after the sixth accepted character abandons the line.
    tbl_valid[1] = 1'b1; tbl_name[1] = rand_name(); tbl_val[1] = $urandom;
    for (int i = 2; i <= 4; i++) tbl_valid[i] = 1'b0;
    clear_mon();
    pulse_start();
    n = 0;
    while (got_q.size() < 6 && n < 200) begin @(negedge clk); n++; end
    check("d_six_accepted", got_q.size(), 6);
    reset = 1'b1;
    @(negedge clk);
    check("d_cvalid", char_valid, 0);
    check("d_dn", display_number, 0);
    check("d_busy", scan_busy, 0);
    check("d_cdata", char_data, 0);
    check("d_line", line_index, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("d_not_resumed", char_valid, 0);
    check("d_idle_busy", scan_busy, 0);
    check("d_no_done", done_pulses, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
